// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the multi-digit seven-segment driver.
// Glyphs are active-low {CA,CB,CC,CD,CE,CF,CG}; the DP bit is added by the top.
package seg_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b000_0001;
  localparam logic [6:0] SEG_1     = 7'b100_1111;
  localparam logic [6:0] SEG_2     = 7'b001_0010;
  localparam logic [6:0] SEG_3     = 7'b000_0110;
  localparam logic [6:0] SEG_4     = 7'b100_1100;
  localparam logic [6:0] SEG_5     = 7'b010_0100;
  localparam logic [6:0] SEG_6     = 7'b010_0000;
  localparam logic [6:0] SEG_7     = 7'b000_1111;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b000_0100;
  localparam logic [6:0] SEG_A     = 7'b000_1000;
  localparam logic [6:0] SEG_B     = 7'b110_0000;
  localparam logic [6:0] SEG_C     = 7'b011_0001;
  localparam logic [6:0] SEG_D     = 7'b100_0010;
  localparam logic [6:0] SEG_E     = 7'b011_0000;
  localparam logic [6:0] SEG_F     = 7'b011_1000;
  localparam logic [6:0] SEG_DASH  = 7'b111_1110;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  // Enough BCD nibbles to hold any value of the given binary width.
  function automatic int bcd_digits(input int value_width);
    return (value_width + 2) / 3;
  endfunction

  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_A;
      4'hB: g = SEG_B;
      4'hC: g = SEG_C;
      4'hD: g = SEG_D;
      4'hE: g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Iterative double-dabble: one shift per cycle, VALUE_WIDTH cycles per conversion.
// done_o is high during the cycle whose closing edge performs the final shift,
// so bcd_o holds the finished result from the following cycle on.
module bin_to_bcd
  import seg_disp_pkg::*;
#(
  parameter int VALUE_WIDTH = 14,
  parameter int BCD_DIGITS  = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [VALUE_WIDTH-1:0]    bin_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [BCD_DIGITS*4-1:0]   bcd_o
);

  localparam int BCD_W = BCD_DIGITS * 4;
  localparam int CNT_W = $clog2(VALUE_WIDTH + 1);

  logic [VALUE_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   last_shift;

  assign last_shift = busy_q && (cnt_q == CNT_W'(VALUE_WIDTH - 1));

  // Add-3 correction on every nibble that would overflow past 9 after shifting.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (bcd_q[k*4 +: 4] >= 4'd5) bcd_adj[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
    end
  end

  // Next-state: load on start, otherwise shift one bit per cycle while busy.
  always_comb begin
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (start_i && !busy_q) begin
      shift_d = bin_i;
      bcd_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
      cnt_d            = cnt_q + CNT_W'(1);
      if (last_shift) busy_d = 1'b0;
    end
  end

  // Conversion registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = last_shift;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/multi_digit_display.sv
// N-digit multiplexed common-anode seven-segment driver with decimal/hex load,
// leading-zero blanking, per-digit DP and blink. The display buffer only
// changes in COMMIT, so the scanned digits never show a half-converted value.
module multi_digit_display
  import seg_disp_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ   = 100_000_000,
  parameter int REFRESH_RATE_HZ = 240,
  parameter int BLINK_RATE_HZ   = 2,
  parameter int NUM_DIGITS      = 4,
  parameter int VALUE_WIDTH     = 14
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [VALUE_WIDTH-1:0] value_i,
  input  logic                   hex_mode_i,
  input  logic                   value_valid_i,
  output logic                   ready_o,
  input  logic                   disp_en_i,
  input  logic                   lzb_en_i,
  input  logic [NUM_DIGITS-1:0]  dot_en_i,
  input  logic [NUM_DIGITS-1:0]  blink_en_i,
  output logic [NUM_DIGITS-1:0]  anodes_o,
  output logic [7:0]             cathodes_o
);

  localparam int BCD_DIGITS = bcd_digits(VALUE_WIDTH);
  localparam int BUF_W      = BCD_DIGITS * 4;
  localparam int PAD_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
  localparam int PAD_W      = PAD_DIGITS * 4;
  localparam int TICK_RAW   = CLOCK_FREQ_HZ / (REFRESH_RATE_HZ * NUM_DIGITS);
  localparam int TICK_DIV   = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int BLINK_RAW  = CLOCK_FREQ_HZ / (2 * BLINK_RATE_HZ);
  localparam int BLINK_DIV  = (BLINK_RAW < 1) ? 1 : BLINK_RAW;
  localparam int TICK_W     = $clog2(TICK_DIV + 1);
  localparam int BLINK_W    = $clog2(BLINK_DIV + 1);
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  state_t                 state_q;
  logic                   ready_q;
  logic                   hex_sel_q;
  logic [VALUE_WIDTH-1:0] hex_val_q;
  logic [BUF_W-1:0]       buf_q;
  logic                   conv_start, conv_busy, conv_done;
  logic [BUF_W-1:0]       conv_bcd;

  logic [TICK_W-1:0]      tick_cnt_q;
  logic [IDX_W-1:0]       scan_idx_q;
  logic [BLINK_W-1:0]     blink_cnt_q;
  logic                   blink_on_q;

  logic [PAD_W-1:0]       buf_pad;
  logic                   overflow;
  logic                   zero_above;
  logic [NUM_DIGITS-1:0]  lz_blank;
  logic [3:0]             sel_nib;
  logic                   sel_lz, sel_dot, sel_blink;
  logic [6:0]             seg;
  logic                   dp_n;
  logic [NUM_DIGITS-1:0]  anodes_d, anodes_q;
  logic [7:0]             cathodes_d, cathodes_q;

  // Handshake (valid/ready): a load happens on a rising edge where
  // value_valid_i && ready_o; value_i and hex_mode_i are sampled on that edge.
  // A request seen while ready_o is low is dropped, never held over.
  assign conv_start = value_valid_i && ready_q && !hex_mode_i;

  bin_to_bcd #(
    .VALUE_WIDTH (VALUE_WIDTH),
    .BCD_DIGITS  (BCD_DIGITS)
  ) u_bin_to_bcd (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (conv_start),
    .bin_i   (value_i),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  // Load FSM: accept, wait for the converter (decimal only), commit to buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      hex_sel_q <= 1'b0;
      hex_val_q <= '0;
      buf_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (value_valid_i) begin
            hex_sel_q <= hex_mode_i;
            hex_val_q <= value_i;
            ready_q   <= 1'b0;
            state_q   <= hex_mode_i ? ST_COMMIT : ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          if (conv_done || !conv_busy) state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          buf_q   <= hex_sel_q ? BUF_W'(hex_val_q) : conv_bcd;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready_o = ready_q;

  // Scan tick divider and digit index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_cnt_q <= '0;
      scan_idx_q <= '0;
    end else if (tick_cnt_q == TICK_W'(TICK_DIV - 1)) begin
      tick_cnt_q <= '0;
      scan_idx_q <= (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
    end else begin
      tick_cnt_q <= tick_cnt_q + TICK_W'(1);
    end
  end

  // Free-running blink phase, 50 % duty, starting in the on phase.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      blink_on_q  <= ~blink_on_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
    end
  end

  // Overflow (nonzero nibble beyond the visible digits) and leading-zero mask.
  always_comb begin
    buf_pad    = PAD_W'(buf_q);
    overflow   = 1'b0;
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int k = NUM_DIGITS; k < PAD_DIGITS; k++) begin
      if (buf_pad[k*4 +: 4] != 4'd0) overflow = 1'b1;
    end
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above  = zero_above && (buf_pad[k*4 +: 4] == 4'd0);
      lz_blank[k] = zero_above;
    end
  end

  // Select the scanned digit and build its segment pattern.
  always_comb begin
    sel_nib   = 4'd0;
    sel_lz    = 1'b0;
    sel_dot   = 1'b0;
    sel_blink = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) == scan_idx_q) begin
        sel_nib   = buf_pad[k*4 +: 4];
        sel_lz    = lz_blank[k];
        sel_dot   = dot_en_i[k];
        sel_blink = blink_en_i[k];
      end
    end
    if (overflow)                seg = SEG_DASH;
    else if (lzb_en_i && sel_lz) seg = SEG_BLANK;
    else                         seg = seg_glyph(sel_nib);
    dp_n = ~sel_dot;
    if (!blink_on_q && sel_blink) begin
      seg  = SEG_BLANK;
      dp_n = 1'b1;
    end
    if (disp_en_i) begin
      anodes_d   = ~(NUM_DIGITS'(1) << scan_idx_q);
      cathodes_d = {seg, dp_n};
    end else begin
      anodes_d   = '1;
      cathodes_d = 8'hFF;
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      anodes_q   <= '1;
      cathodes_q <= 8'hFF;
    end else begin
      anodes_q   <= anodes_d;
      cathodes_q <= cathodes_d;
    end
  end

  assign anodes_o   = anodes_q;
  assign cathodes_o = cathodes_q;

endmodule

// File: tb/tb_multi_digit_display.sv
// Bench for multi_digit_display with small clock/rate parameters so the scan
// and blink periods are short: scan tick every 10 cycles, blink half period 120.
module tb_multi_digit_display;

  localparam int CLK_HZ = 9600;
  localparam int REF_HZ = 240;
  localparam int BLK_HZ = 40;
  localparam int ND     = 4;
  localparam int VW     = 14;
  localparam int TICK   = CLK_HZ / (REF_HZ * ND);
  localparam int HALF   = CLK_HZ / (2 * BLK_HZ);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [VW-1:0] value    = '0;
  logic          hex_mode = 1'b0;
  logic          valid    = 1'b0;
  logic          ready;
  logic          disp_en  = 1'b1;
  logic          lzb_en   = 1'b1;
  logic [ND-1:0] dot_en   = '0;
  logic [ND-1:0] blink_en = '0;
  logic [ND-1:0] anodes;
  logic [7:0]    cathodes;

  multi_digit_display #(
    .CLOCK_FREQ_HZ   (CLK_HZ),
    .REFRESH_RATE_HZ (REF_HZ),
    .BLINK_RATE_HZ   (BLK_HZ),
    .NUM_DIGITS      (ND),
    .VALUE_WIDTH     (VW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .value_i       (value),
    .hex_mode_i    (hex_mode),
    .value_valid_i (valid),
    .ready_o       (ready),
    .disp_en_i     (disp_en),
    .lzb_en_i      (lzb_en),
    .dot_en_i      (dot_en),
    .blink_en_i    (blink_en),
    .anodes_o      (anodes),
    .cathodes_o    (cathodes)
  );

  int total = 0;
  int bad   = 0;
  int cyc;

  // Edges since reset release; the output sampled after edge e reflects
  // the scan/blink state that existed just before edge e.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- reference model ----------------
  int m_val = 0;
  bit m_hex = 1'b0;

  // Active-low {a..g,dp} with DP off, glyphs 0..F.
  logic [7:0] glyph_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                 8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  function automatic logic [7:0] model_cath(input int k, input bit phase_on);
    int base;
    int place;
    int limit;
    int dig;
    logic [7:0] c;
    base  = m_hex ? 16 : 10;
    place = 1;
    for (int i = 0; i < k; i++) place = place * base;
    limit = 1;
    for (int i = 0; i < ND; i++) limit = limit * base;
    dig = (m_val / place) % base;
    if (m_val >= limit)                      c = 8'hFD;
    else if (lzb_en && k > 0 && m_val < place) c = 8'hFF;
    else                                     c = glyph_tab[dig];
    if (dot_en[k]) c[0] = 1'b0;
    if (!phase_on && blink_en[k]) c = 8'hFF;
    return c;
  endfunction

  task automatic expected_outputs(output logic [ND-1:0] ea, output logic [7:0] ec);
    int idx;
    bit ph;
    idx = ((cyc - 1) / TICK) % ND;
    ph  = (((cyc - 1) / HALF) % 2) == 0;
    if (disp_en) begin
      ea = ~(ND'(1) << idx);
      ec = model_cath(idx, ph);
    end else begin
      ea = '1;
      ec = 8'hFF;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Issues one load from idle and counts sampled cycles with ready low.
  task automatic drive_load(input int val, input bit hex, output int lows);
    @(negedge clk);
    value    = VW'(val);
    hex_mode = hex;
    valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    lows  = 0;
    while (ready !== 1'b1 && lows < 100) begin
      lows++;
      @(negedge clk);
    end
    m_val = val;
    m_hex = hex;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [ND-1:0] ea;
    logic [7:0] ec;
    disp_en = 1'b1; lzb_en = 1'b1; dot_en = '0; blink_en = '0;
    drive_reset(3);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
    total++; if (anodes !== 4'hF) begin bad++; $display("FAIL reset_anodes got=%b want=1111", anodes); end
    total++; if (cathodes !== 8'hFF) begin bad++; $display("FAIL reset_cathodes got=%h want=ff", cathodes); end
    rst = 1'b0;
    m_val = 0; m_hex = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      expected_outputs(ea, ec);
      total++; if (anodes !== ea) begin bad++; $display("FAIL reset_scan_anodes cyc=%0d got=%b want=%b", cyc, anodes, ea); end
      total++; if (cathodes !== ec) begin bad++; $display("FAIL reset_scan_cathodes cyc=%0d got=%h want=%h", cyc, cathodes, ec); end
    end
  endtask

  task automatic test_decimal();
    int lows;
    int vals [3] = '{9999, 10000, 0};
    logic [ND-1:0] ea;
    logic [7:0] ec;
    foreach (vals[j]) begin
      drive_load(vals[j], 1'b0, lows);
      total++; if (lows !== VW + 1) begin bad++; $display("FAIL dec_busy val=%0d got=%0d want=%0d", vals[j], lows, VW + 1); end
      @(negedge clk);
      for (int i = 0; i < 42; i++) begin
        @(negedge clk);
        expected_outputs(ea, ec);
        total++; if (anodes !== ea) begin bad++; $display("FAIL dec_anodes val=%0d got=%b want=%b", vals[j], anodes, ea); end
        total++; if (cathodes !== ec) begin bad++; $display("FAIL dec_cathodes val=%0d got=%h want=%h", vals[j], cathodes, ec); end
      end
    end
  endtask

  task automatic test_hex();
    int lows;
    logic [ND-1:0] ea;
    logic [7:0] ec;
    drive_load(14'h2A3F, 1'b1, lows);
    total++; if (lows !== 1) begin bad++; $display("FAIL hex_busy got=%0d want=1", lows); end
    @(negedge clk);
    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      expected_outputs(ea, ec);
      total++; if (anodes !== ea) begin bad++; $display("FAIL hex_anodes got=%b want=%b", anodes, ea); end
      total++; if (cathodes !== ec) begin bad++; $display("FAIL hex_cathodes got=%h want=%h", cathodes, ec); end
    end
  endtask

  task automatic test_lzb();
    int lows;
    logic [ND-1:0] ea;
    logic [7:0] ec;
    drive_load(42, 1'b0, lows);
    @(negedge clk);
    for (int pass = 0; pass < 2; pass++) begin
      lzb_en = (pass == 0);
      @(negedge clk);
      for (int i = 0; i < 42; i++) begin
        @(negedge clk);
        expected_outputs(ea, ec);
        total++; if (cathodes !== ec) begin bad++; $display("FAIL lzb%0d_cathodes cyc=%0d got=%h want=%h", lzb_en, cyc, cathodes, ec); end
      end
    end
    lzb_en = 1'b1;
  endtask

  task automatic test_blink_dot();
    int lows;
    logic [ND-1:0] ea;
    logic [7:0] ec;
    drive_load(1234, 1'b0, lows);
    @(negedge clk);
    blink_en = 4'b0001;
    dot_en   = 4'b0010;
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      expected_outputs(ea, ec);
      total++; if (anodes !== ea) begin bad++; $display("FAIL blink_anodes cyc=%0d got=%b want=%b", cyc, anodes, ea); end
      total++; if (cathodes !== ec) begin bad++; $display("FAIL blink_cathodes cyc=%0d got=%h want=%h", cyc, cathodes, ec); end
    end
    blink_en = '0;
    dot_en   = '0;
  endtask

  task automatic test_ignored_request();
    int lows;
    logic [ND-1:0] ea;
    logic [7:0] ec;
    @(negedge clk);
    value = VW'(5678); hex_mode = 1'b0; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    value = VW'(14'h1ABC); hex_mode = 1'b1;
    lows = 0;
    while (ready !== 1'b1 && lows < 100) begin
      lows++;
      if (lows == 10) valid = 1'b0;
      @(negedge clk);
    end
    valid = 1'b0;
    m_val = 5678; m_hex = 1'b0;
    total++; if (lows !== VW + 1) begin bad++; $display("FAIL ignore_busy got=%0d want=%0d", lows, VW + 1); end
    @(negedge clk);
    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      expected_outputs(ea, ec);
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL ignore_ready got=%b want=1", ready); end
      total++; if (cathodes !== ec) begin bad++; $display("FAIL ignore_cathodes got=%h want=%h", cathodes, ec); end
    end
  endtask

  task automatic test_reset_mid_convert();
    logic [ND-1:0] ea;
    logic [7:0] ec;
    @(negedge clk);
    value = VW'(777); hex_mode = 1'b0; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", ready); end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", ready); end
    rst = 1'b0;
    m_val = 0; m_hex = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      expected_outputs(ea, ec);
      total++; if (anodes !== ea) begin bad++; $display("FAIL midrst_anodes got=%b want=%b", anodes, ea); end
      total++; if (cathodes !== ec) begin bad++; $display("FAIL midrst_cathodes got=%h want=%h", cathodes, ec); end
    end
  endtask

  task automatic test_random();
    int lows;
    int val;
    bit hex;
    logic [ND-1:0] ea;
    logic [7:0] ec;
    for (int j = 0; j < 16; j++) begin
      val = $urandom_range(0, (1 << VW) - 1);
      if (j % 4 == 0) val = $urandom_range(0, 120);
      hex = $urandom_range(0, 1);
      drive_load(val, hex, lows);
      total++; if (lows !== (hex ? 1 : VW + 1)) begin bad++; $display("FAIL rand_busy val=%0d got=%0d", val, lows); end
      @(negedge clk);
      disp_en  = ($urandom_range(0, 5) != 0);
      lzb_en   = $urandom_range(0, 1);
      dot_en   = ND'($urandom_range(0, 15));
      blink_en = ND'($urandom_range(0, 15));
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        expected_outputs(ea, ec);
        total++; if (anodes !== ea) begin bad++; $display("FAIL rand_anodes val=%0d hex=%0d got=%b want=%b", val, hex, anodes, ea); end
        total++; if (cathodes !== ec) begin bad++; $display("FAIL rand_cathodes val=%0d hex=%0d got=%h want=%h", val, hex, cathodes, ec); end
      end
    end
    disp_en = 1'b1; lzb_en = 1'b1; dot_en = '0; blink_en = '0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_decimal();
    test_hex();
    test_lzb();
    test_blink_dot();
    test_ignored_request();
    test_reset_mid_convert();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_digit_display.md
# multi_digit_display

Parametrised successor to the fixed four-digit display driver: drives an N-digit, time-multiplexed, common-anode seven-segment display from a binary value. Supports decimal mode via an iterative double-dabble converter, hex mode, leading-zero blanking, per-digit decimal points and per-digit blinking. The display buffer is double-buffered, so digits never glitch mid-conversion. Sits between the debounced switch/bus inputs and the board display pins.

## Interface
- CLOCK_FREQ_HZ, 100_000_000, system clock frequency.
- REFRESH_RATE_HZ, 240, full-display refresh rate.
- BLINK_RATE_HZ, 2, blink frequency at 50 % duty.
- NUM_DIGITS, 4, digit count (2..8).
- VALUE_WIDTH, 14, width of the binary input (1..27).
- clk_i  in  1  system clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- value_i  in  VALUE_WIDTH  binary value to display.
- hex_mode_i  in  1  1 = hex, 0 = decimal; sampled with value_i.
- value_valid_i  in  1  load request.
- ready_o  out  1  block can accept a load.
- disp_en_i  in  1  0 = all anodes off; scanning continues.
- lzb_en_i  in  1  leading-zero blanking enable (live).
- dot_en_i  in  NUM_DIGITS  per-digit DP enable; bit 0 = rightmost (live).
- blink_en_i  in  NUM_DIGITS  per-digit blink enable (live).
- anodes_o  out  NUM_DIGITS  active-low one-hot digit select; MSB = leftmost.
- cathodes_o  out  8  active-low {CA,CB,CC,CD,CE,CF,CG,DP}; bit 7 = CA.

## Operation
- Handshake: a load occurs when value_valid_i && ready_o at a rising edge. value_i and hex_mode_i are captured at that edge. A request while ready_o = 0 is ignored, not queued.
- FSM states: IDLE (ready_o = 1), CONVERT (ready_o = 0), COMMIT (ready_o = 0).
  - IDLE→CONVERT on a decimal load.
  - IDLE→COMMIT on a hex load.
  - CONVERT runs exactly VALUE_WIDTH shift cycles, then →COMMIT.
  - COMMIT writes the display buffer, then →IDLE.
- Decimal conversion uses BCD_DIGITS = (VALUE_WIDTH+2)/3 nibbles. Before each shift, add 3 to every nibble ≥ 5.
- Hex mode: nibble k = value[4k+3:4k]; bits above VALUE_WIDTH read as zero.
- Overflow: any nonzero nibble at index ≥ NUM_DIGITS means every digit shows dash (CG only) and leading-zero blanking is ignored.
- Leading-zero blanking (when enabled): blank every zero digit above the most significant nonzero digit. Digit 0 is always shown.
- Blink: a free-running phase toggles every CLOCK_FREQ_HZ/(2·BLINK_RATE_HZ) cycles. During the off phase, digits with blink_en_i set are fully blank, including DP.
- DP is lit when dot_en_i[k] is set and the digit is not blink-blanked. DP is unaffected by leading-zero blanking.
- Scan: a tick fires every CLOCK_FREQ_HZ/(REFRESH_RATE_HZ·NUM_DIGITS) cycles; the scan index then increments, wrapping NUM_DIGITS-1→0.
- Decode 0–F with standard glyphs; dash = CG only; blank = all segments off.

## Timing
- Reset (synchronous): FSM→IDLE, ready_o = 1, display buffer = 0, scan index = 0, tick and blink counters = 0, blink phase = on, anodes_o = all 1, cathodes_o = 8'hFF.
- First cycle after reset with disp_en_i = 1: shows "0" (lzb on) or "000…0" (lzb off).
- Decimal load at edge t: ready_o low from t+1; buffer updated at t+VALUE_WIDTH+1; ready_o high at t+VALUE_WIDTH+2.
- Hex load at edge t: buffer updated at t+1; ready_o high at t+2.
- anodes_o and cathodes_o are registered, one cycle after the scan index, disp_en_i or live controls change.
- Reset during CONVERT or COMMIT aborts the conversion; the buffer returns to 0.
- Live inputs (disp_en_i, lzb_en_i, dot_en_i, blink_en_i) take effect on the next output register update. They never affect a conversion in flight.

## Structure
- Package seg_disp_pkg holds:
  - 7-bit glyph constants for 0–F, SEG_DASH and SEG_BLANK;
  - the FSM state enum;
  - a function computing BCD_DIGITS.
- Sub-module bin_to_bcd contains the iterative double-dabble core: start/busy/done plus a BCD_DIGITS×4 result. The top level owns the handshake, buffer, scan, blink and decode logic.

## Test plan
- Reset with disp_en_i = 1, lzb_en_i = 1, NUM_DIGITS = 4 → anodes cycle 1110,1101,1011,0111. Digit 0 cathodes = 0000_0011 ('0'); the other digits read 8'hFF.
- Decimal load 9999, VALUE_WIDTH = 14 → ready_o low for 15 cycles. All digits then decode '9' (0000_1001 with DP off).
- Decimal load 10000 → all four digits show dash (1111_1101). Hex load 14'h2A3F → digits '2','A','3','F'.
- Decimal load 42, lzb_en_i = 1 → digits 3 and 2 blank, digits 1 and 0 show '4','2'. With lzb_en_i = 0 → "0042".
- blink_en_i = 4'b0001, dot_en_i = 4'b0010 → digit 0 alternates glyph/8'hFF each half-period; digit 1 DP bit = 0.
- value_valid_i held during CONVERT → ignored. Assert rst_i mid-CONVERT → buffer = 0 and ready_o = 1 on the next cycle.
